// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   N_REQ   : number of requesters
//   state_t : arbiter FSM states (IDLE = no owner, GRANT = one owner)
//   rr_next : round-robin winner, priority last+1, last+2, last+3, last
//   onehot4 : 2-bit index to one-hot grant vector
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Walks from lowest priority (last itself) to highest (last+1); the final
  // match wins. Returns last when nothing is requesting; callers gate on |req.
  function automatic logic [1:0] rr_next(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       last);
    logic [1:0] idx;
    rr_next = last;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      idx = last + k[1:0];
      if (req[idx]) rr_next = idx;
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] w);
    onehot4 = 4'b0001 << w;
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Existing 4:1 mux cell.
//   i0..i3 : data inputs
//   s1, s0 : select (s1 = MSB)
//   out    : selected input
module MUX4X1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic out
);

  always_comb begin
    out = 1'b0;
    case ({s1, s0})
      2'b00: out = i0;
      2'b01: out = i1;
      2'b10: out = i2;
      2'b11: out = i3;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 mux.
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   req[3:0] : per-requester request, held while the mux is needed
//   din[3:0] : per-requester data bit (mux inputs)
//   gnt[3:0] : registered one-hot grant
//   sel1/0   : registered mux select, holds while idle
//   valid    : registered, equals |gnt
//   dout     : mux output gated by valid
// An owner keeps the mux for at most HOLD_MAX consecutive cycles, then the
// arbiter re-arbitrates with the owner ranked last.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic             sel1,
  output logic             sel0,
  output logic             valid,
  output logic             dout
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q;
  logic [1:0]       winner;
  logic             mux_out;

  // Owner is always last after a grant, so the same priority walk makes the
  // current owner rank last on timeout and re-grants it when alone.
  assign winner = rr_next(req, last_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = onehot4(winner);
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = '0;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        if (req[sel_q] && (cnt_q != 8'(HOLD_MAX - 1))) begin
          cnt_d = cnt_q + 8'd1;
        end else if (|req) begin
          gnt_d  = onehot4(winner);
          sel_d  = winner;
          last_d = winner;
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= |gnt_d;
    end
  end

  MUX4X1 u_mux (
    .i0  (din[0]),
    .i1  (din[1]),
    .i2  (din[2]),
    .i3  (din[3]),
    .s1  (sel_q[1]),
    .s0  (sel_q[0]),
    .out (mux_out)
  );

  assign gnt   = gnt_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign valid = valid_q;
  assign dout  = mux_out & valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       sel1, sel0, valid, dout;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel1  (sel1),
    .sel0  (sel0),
    .valid (valid),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state
  logic [3:0] m_gnt  = '0;
  logic [1:0] m_sel  = '0;
  logic [1:0] m_last = 2'd3;
  int         m_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] rq, input logic [1:0] lst);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(lst) + k) % 4;
      if (rq[idx]) return 2'(idx);
    end
    return lst;
  endfunction

  task automatic m_grant(input logic [1:0] w);
    m_gnt  = 4'b0001 << w;
    m_sel  = w;
    m_last = w;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [3:0] rq, input logic rs);
    if (rs) begin
      m_gnt = '0; m_sel = '0; m_last = 2'd3; m_cnt = 0;
    end else if (m_gnt == 4'b0) begin
      if (rq != 4'b0) m_grant(pick(rq, m_last));
    end else if (rq[m_sel]) begin
      if (m_cnt == int'(HOLD) - 1) m_grant(pick(rq, m_last));
      else m_cnt++;
    end else if (rq != 4'b0) begin
      m_grant(pick(rq, m_last));
    end else begin
      m_gnt = '0;
      m_cnt = 0;
    end
  endtask

  // Drive one cycle of stimulus, queue the expected registered result, then
  // compare #1 after the edge.
  task automatic step(input logic [3:0] rq, input logic [3:0] dn, input logic rs);
    exp_t e;
    req = rq; din = dn; reset = rs;
    model_step(rq, rs);
    exp_q.push_back('{gnt: m_gnt, sel: m_sel, valid: (m_gnt != 4'b0)});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("gnt",   32'(gnt),          32'(e.gnt));
      check_val("sel",   32'({sel1, sel0}), 32'(e.sel));
      check_val("valid", 32'(valid),        32'(e.valid));
      check_val("dout",  32'(dout),         32'(e.valid ? din[e.sel] : 1'b0));
    end
  endtask

  initial begin
    req = '0; din = '0; reset = 1'b1;
    @(negedge clk);

    // Reset state
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    check_val("rst_gnt",   32'(gnt),   32'h0);
    check_val("rst_valid", 32'(valid), 32'h0);
    check_val("rst_dout",  32'(dout),  32'h0);

    // Single request, one-cycle latency
    step(4'b0001, 4'b0001, 1'b0);
    check_val("first_gnt",  32'(gnt),          32'h1);
    check_val("first_sel",  32'({sel1, sel0}), 32'h0);
    check_val("first_dout", 32'(dout),         32'h1);

    // All requesting: each owner exactly HOLD cycles, no gaps
    step(4'b0000, 4'b0000, 1'b1);
    for (int t = 0; t < 5 * int'(HOLD); t++) begin
      step(4'b1111, 4'($urandom_range(0, 15)), 1'b0);
      check_val("rot_gnt", 32'(gnt), 32'(4'b0001 << ((t / int'(HOLD)) % 4)));
    end

    // Owner 1 releases while 2 is pending
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 1'b0);
    check_val("hold1_gnt", 32'(gnt), 32'h2);
    step(4'b0100, 4'b0100, 1'b0);
    check_val("hand_gnt",   32'(gnt),          32'h4);
    check_val("hand_sel",   32'({sel1, sel0}), 32'h2);
    check_val("hand_valid", 32'(valid),        32'h1);

    // All drop: idle, sel holds 10
    step(4'b0000, 4'b1111, 1'b0);
    check_val("drop_valid", 32'(valid),        32'h0);
    check_val("drop_sel",   32'({sel1, sel0}), 32'h2);
    for (int d = 0; d < 16; d++) step(4'b0000, 4'(d), 1'b0);

    // Only requester 3 for 20 cycles: timeout re-grants with no valid drop
    for (int t = 0; t < 20; t++) begin
      step(4'b1000, 4'($urandom_range(0, 15)), 1'b0);
      check_val("solo_gnt",   32'(gnt),   32'h8);
      check_val("solo_valid", 32'(valid), 32'h1);
    end

    // Reset mid-grant, then last = 3 favours requester 1 over 2
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 1'b0);
    check_val("pre_rst_gnt", 32'(gnt), 32'h4);
    step(4'b0110, 4'b0000, 1'b1);
    check_val("mid_rst_gnt", 32'(gnt), 32'h0);
    step(4'b0110, 4'b0000, 1'b0);
    check_val("post_rst_gnt", 32'(gnt), 32'h2);

    // Random traffic with sticky requests and occasional reset
    begin
      logic [3:0] rq;
      rq = '0;
      for (int t = 0; t < 400; t++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
        step(rq, 4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
